stage_mem: RTL and testbench

STAGE_MEM -- requirements
Module: stage_mem

---
 rtl/stage_mem_pkg.sv | 13 +
 rtl/stage_mem_data_mem.sv | 38 +++
 rtl/stage_mem.sv | 39 +++
 tb/tb_stage_mem.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/stage_mem_pkg.sv
// Shared pipeline constants for the memory stage: word width, default
// data-memory depth and the helper that sizes the word index.
package stage_mem_pkg;

  localparam int WORD_W          = 32;
  localparam int DEPTH_WORDS_DEF = 64;

  // Number of index bits needed to select one of depth words.
  function automatic int mem_idx_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/stage_mem_data_mem.sv
// Data memory array: synchronous write port, asynchronous read port and an
// optional synchronous clear on reset. DEPTH must be a power of two (>= 4) so
// that the index width covers the array exactly.
module data_mem
  import stage_mem_pkg::*;
#(
  parameter int DEPTH     = DEPTH_WORDS_DEF,
  parameter int INIT_ZERO = 1,
  localparam int IDX_W    = mem_idx_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [WORD_W-1:0] wd_i,
  output logic [WORD_W-1:0] rd_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  // Reset clears the array (when enabled) and always wins over a write;
  // otherwise a write stores the full word at the addressed index.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (INIT_ZERO != 0) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_q[i] <= '0;
        end
      end
    end else if (we_i == 1'b1) begin
      mem_q[addr_i] <= wd_i;
    end
  end

  // Zero-latency read with no bypass: the word only changes after the edge.
  assign rd_o = mem_q[addr_i];

endmodule

// File: rtl/stage_mem.sv
// Memory stage of the pipeline: turns the execute-stage byte address into a
// word index and reads/writes the data memory. Byte offset bits and address
// bits above the index are dropped, so accesses wrap modulo the array size.
module stage_mem
  import stage_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int INIT_ZERO   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] aluout,
  input  logic [31:0] wd,
  output logic [31:0] rd
);

  localparam int IDX_W = mem_idx_w(DEPTH_WORDS);

  logic [IDX_W-1:0] mem_idx;
  logic             unused_addr_bits;

  // Word index: skip the byte offset, keep just enough bits for the array.
  assign mem_idx          = aluout[IDX_W+1:2];
  assign unused_addr_bits = ^{aluout[31:IDX_W+2], aluout[1:0]};

  data_mem #(
    .DEPTH     (DEPTH_WORDS),
    .INIT_ZERO (INIT_ZERO)
  ) u_data_mem (
    .clk    (clk),
    .reset  (reset),
    .we_i   (memwrite),
    .addr_i (mem_idx),
    .wd_i   (wd),
    .rd_o   (rd)
  );

endmodule

// File: tb/tb_stage_mem.sv
// Self-checking bench for stage_mem: directed scenarios for the documented
// behaviours followed by randomized traffic against a word-array model.
module tb_stage_mem;

  localparam int DEPTH = 64;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] aluout = '0;
  logic [31:0] wd = '0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  stage_mem #(
    .DEPTH_WORDS (DEPTH),
    .INIT_ZERO   (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .memwrite (memwrite),
    .aluout   (aluout),
    .wd       (wd),
    .rd       (rd)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] model [DEPTH];
  logic [31:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  // Byte address -> word slot: wrap modulo the array size in bytes, then /4.
  function automatic int word_of(input logic [31:0] addr);
    return int'((addr % 32'(4 * DEPTH)) / 32'd4);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock edge with the given controls; the model follows the same edge.
  task automatic step(input logic rst, input logic we, input logic [31:0] addr,
                      input logic [31:0] data);
    @(negedge clk);
    reset = rst; memwrite = we; aluout = addr; wd = data;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
    end else if (we) begin
      model[word_of(addr)] = data;
    end
    #1;
  endtask

  // Combinational read between edges, compared through the expected queue.
  task automatic read_check(input string tag, input logic [31:0] addr);
    reset = 1'b0; memwrite = 1'b0; aluout = addr;
    exp_q.push_back(model[word_of(addr)]);
    #1;
    check(tag, rd, exp_q.pop_front());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int          op;

    for (int i = 0; i < DEPTH; i++) model[i] = 'x;

    // Reset for one cycle: every word reads 0.
    step(1'b1, 1'b0, 32'h0, 32'h0);
    read_check("reset_a0", 32'h0);
    read_check("reset_a4", 32'h4);
    read_check("reset_top", 32'(4 * DEPTH - 4));

    // Basic write.
    step(1'b0, 1'b1, 32'h0, 32'hAABBCCDD);
    read_check("basic_wr", 32'h0);

    // Address aliasing: byte offsets and wrap.
    step(1'b0, 1'b1, 32'h8, 32'h11223344);
    read_check("alias_9", 32'h9);
    read_check("alias_10", 32'hA);
    read_check("alias_11", 32'hB);
    read_check("alias_wrap", 32'(8 + 4 * DEPTH));
    check("alias_wrap_const", rd, 32'h11223344);

    // Write disabled.
    step(1'b0, 1'b0, 32'h4, 32'hFFFFFFFF);
    read_check("wr_disabled", 32'h4);
    check("wr_disabled_zero", rd, 32'h0);

    // Word isolation.
    step(1'b0, 1'b1, 32'h0, 32'hA);
    step(1'b0, 1'b1, 32'h4, 32'hB);
    read_check("iso_0", 32'h0);
    check("iso_0_const", rd, 32'hA);
    read_check("iso_4", 32'h4);
    check("iso_4_const", rd, 32'hB);
    read_check("iso_8_kept", 32'h8);

    // Combinational read, no bypass: old value before edge, new after.
    step(1'b0, 1'b1, 32'hC, 32'h0BAD0001);
    @(negedge clk);
    memwrite = 1'b1; aluout = 32'hC; wd = 32'h12345678;
    #1;
    check("nobypass_old", rd, 32'h0BAD0001);
    @(posedge clk);
    model[word_of(32'hC)] = 32'h12345678;
    #1;
    check("nobypass_new", rd, 32'h12345678);
    memwrite = 1'b0;

    // Back-to-back writes to same and different indices.
    step(1'b0, 1'b1, 32'h10, 32'h1);
    step(1'b0, 1'b1, 32'h10, 32'h2);
    step(1'b0, 1'b1, 32'h14, 32'h3);
    read_check("b2b_same", 32'h10);
    read_check("b2b_diff", 32'h14);

    // Reset raised mid-cycle acts only at the next edge.
    @(negedge clk);
    reset = 1'b1; memwrite = 1'b0; aluout = 32'h10;
    #1;
    check("midrst_before", rd, 32'h2);
    @(posedge clk);
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    #1;
    check("midrst_after", rd, 32'h0);
    reset = 1'b0;

    // Reset priority over a simultaneous write.
    step(1'b0, 1'b1, 32'h0, 32'h99);
    step(1'b1, 1'b1, 32'h0, 32'h5);
    read_check("rst_prio", 32'h0);
    check("rst_prio_zero", rd, 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      op = $urandom_range(0, 39);
      a  = $urandom;
      d  = $urandom;
      if (op == 0)       step(1'b1, 1'($urandom_range(0, 1)), a, d);
      else if (op < 24)  step(1'b0, 1'b1, a, d);
      else               step(1'b0, 1'b0, a, d);
      if ($urandom_range(0, 1) == 1) read_check("rand_same", a ^ 32'($urandom_range(0, 3)));
      else                           read_check("rand_any", $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
